fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Run controller in front of the instruction fetch unit.
- On a start request it issues the fetch unit's init pulse with a start address, then enables fetching until a halt instruction or a watchdog timeout, and reports completion.
- Mirrors the fetch unit's 2-bit program-slot counter so the top level always knows which ROM is executing. Slot 0 holds no program and is skipped automatically.

Parameters:
- ADDR_W, 9, instruction address / start address width
- INST_W, 9, instruction width
- HALT_INST, 9'h1FF, encoding that terminates a program
- CNT_W, 16, cycle-counter width
- MAX_CYCLES, 16'hFFFF, watchdog limit in RUN cycles

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to run the next program; sampled only in IDLE
- start_addr  in  ADDR_W  first PC of the program; captured with start
- stall  in  1  datapath stall; holds PC while high
- inst  in  INST_W  current instruction from fetch unit
- init  out  1  init pulse to fetch unit
- fetch_unit_en  out  1  fetch enable to fetch unit
- start_address  out  ADDR_W  start address to fetch unit
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky; run ended by watchdog
- prog_id  out  2  program slot currently selected in fetch unit (1..3; 0 = none yet)
- cycle_count  out  CNT_W  RUN cycles of current/last program

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - init, fetch_unit_en, busy, done and timeout are 0.
  - start_address, prog_id and cycle_count are 0.
- State IDLE:
  - Outputs idle.
  - start=1 latches start_addr into start_address, clears cycle_count and timeout, sets busy.
  - Next state: SKIP if prog_id==3, else LOAD.
- State SKIP (one cycle):
  - init=1, fetch_unit_en=0.
  - prog_id becomes 0, mirroring the fetch unit's wrap into the empty slot.
  - Next state: LOAD.
- State LOAD (one cycle):
  - init=1, fetch_unit_en=0.
  - prog_id increments.
  - Next state: SETTLE.
- State SETTLE (one cycle):
  - init=0, fetch_unit_en=0.
  - Lets the new PC drive a valid inst.
  - Next state: RUN.
- State RUN:
  - fetch_unit_en = ~stall.
  - cycle_count increments every cycle, stalled or not, and saturates at all-ones.
  - If inst==HALT_INST and stall==0: fetch_unit_en is forced 0 that cycle (PC stays on the halt), go to FIN.
  - Else if cycle_count==MAX_CYCLES-1: set timeout, fetch_unit_en=0, go to FIN.
  - If halt and watchdog hit in the same cycle, halt wins and timeout stays 0.
  - A halt seen while stall=1 is ignored until stall drops.
- State FIN (one cycle):
  - done=1, busy=0.
  - cycle_count and timeout hold their values until the next accepted start.
  - Next state: IDLE.
- start while not IDLE is ignored; no queuing.
- start_address holds its value after LOAD; it changes only on an accepted start.
- Start-to-first-enabled-fetch latency:
  - 3 cycles normally (IDLE→LOAD→SETTLE→RUN).
  - 4 cycles when skipping slot 0.
- Reset mid-run:
  - All outputs clear immediately; prog_id returns to 0.
  - The fetch unit's own program counter is not reset. The integrator must reset both together.
- Outputs are registered. fetch_unit_en is the only output combinational on stall and inst; it is used only in RUN.

Test Plan:
- Basic run:
  - Stimulus: rst_n low→high, start=1 with start_addr=9'h010; inst=9'h001 for 5 RUN cycles, then 9'h1FF.
  - Required: init high for exactly 1 cycle, with start_address=9'h010 and prog_id=1 that cycle.
  - Required: fetch_unit_en high for 5 cycles, done pulse, cycle_count=6, timeout=0.
- Stall:
  - Stimulus: as basic run, with stall=1 for 3 cycles mid-run and a halt presented during the stall.
  - Required: fetch_unit_en=0 during the stall.
  - Required: the halt is only recognised on the first cycle after stall drops; cycle_count includes the 3 stall cycles.
- Watchdog:
  - Stimulus: MAX_CYCLES=8, never present a halt.
  - Required: after 8 RUN cycles timeout=1, one done pulse, cycle_count=8.
  - Required: timeout stays 1 until the next start, and clears on that start.
- Slot wrap:
  - Stimulus: run three programs back to back, then a fourth start.
  - Required: prog_id goes 1,2,3.
  - Required: on the fourth start there are two consecutive init pulses (SKIP then LOAD), and prog_id ends at 1.
- Ignored start and async reset:
  - Stimulus: pulse start during RUN; then drop rst_n mid-RUN.
  - Required: the start pulse has no effect and busy stays 1.
  - Required: on reset, all outputs are 0 before the next clk edge; a later start yields prog_id=1.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run-control and fetch-unit signals of fetch_sequencer in one bundle.
// Ports: start/start_addr request a run; stall/inst come back from the fetch unit; init,
//        fetch_unit_en, start_address drive the fetch unit; busy/done/timeout/prog_id/cycle_count report.
// master = the sequencer itself, slave = its environment (requester plus fetch unit).
interface fetch_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int INST_W = 9,
    parameter int CNT_W  = 16
);
    // requester / fetch unit -> sequencer
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stall;
    logic [INST_W-1:0] inst;

    // sequencer -> fetch unit
    logic              init;
    logic              fetch_unit_en;
    logic [ADDR_W-1:0] start_address;

    // sequencer -> requester status
    logic              busy;
    logic              done;
    logic              timeout;
    logic [1:0]        prog_id;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        input  start, start_addr, stall, inst,
        output init, fetch_unit_en, start_address,
        output busy, done, timeout, prog_id, cycle_count
    );

    modport slave (
        output start, start_addr, stall, inst,
        input  init, fetch_unit_en, start_address,
        input  busy, done, timeout, prog_id, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: run controller in front of the fetch unit (init pulse, fetch enable, halt/watchdog, slot mirror).
// Latency: start to first enabled fetch is 3 cycles, 4 when the empty slot 0 must be skipped.
// Backpressure: stall holds fetch_unit_en low but the RUN cycle counter keeps counting; start is ignored unless IDLE.
// Ports: clk, rst_n (async active-low) plus bus (fetch_sequencer_if.master) carrying all request, fetch and status signals.
module fetch_sequencer #(
    parameter int                ADDR_W     = 9,
    parameter int                INST_W     = 9,
    parameter logic [INST_W-1:0] HALT_INST  = 9'h1FF,
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  MAX_CYCLES = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus
);

    // cycle_count value seen during the last RUN cycle the watchdog allows
    localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SKIP   = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] start_addr_q;
    logic [1:0]        prog_id_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic              timeout_q;

    logic              halt_seen;
    logic              wd_hit;
    logic              init_o;
    logic              fetch_en_o;
    logic              busy_o;
    logic              done_o;

    // A halt only counts once the datapath is not stalled; halt beats the watchdog.
    assign halt_seen = (bus.inst == HALT_INST) && !bus.stall;
    assign wd_hit    = (cycle_cnt_q == WD_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // The fetch unit wraps 3 -> 0, and slot 0 is empty, so an extra init is needed.
                if (bus.start) begin
                    state_d = (prog_id_q == 2'd3) ? S_SKIP : S_LOAD;
                end
            end
            S_SKIP:   state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_RUN;
            S_RUN: begin
                if (halt_seen || wd_hit) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Everything except fetch_unit_en depends on the state register alone.
    always_comb begin
        init_o     = 1'b0;
        fetch_en_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            S_SKIP, S_LOAD: begin
                init_o = 1'b1;
                busy_o = 1'b1;
            end
            S_SETTLE: busy_o = 1'b1;
            S_RUN: begin
                busy_o = 1'b1;
                // Leaving RUN this cycle: keep the PC parked on the halt / last instruction.
                fetch_en_o = !bus.stall && !halt_seen && !wd_hit;
            end
            S_FIN:   done_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_addr_q <= '0;
            prog_id_q    <= '0;
            cycle_cnt_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                start_addr_q <= bus.start_addr;
                cycle_cnt_q  <= '0;
                timeout_q    <= 1'b0;
            end

            // prog_id is updated on entry to SKIP/LOAD so it already shows the
            // slot being initialised while init is high.
            if (state_d == S_SKIP) begin
                prog_id_q <= 2'd0;
            end else if (state_d == S_LOAD) begin
                prog_id_q <= prog_id_q + 2'd1;
            end

            if (state_q == S_RUN) begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                end
                if (!halt_seen && wd_hit) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.init          = init_o;
    assign bus.fetch_unit_en = fetch_en_o;
    assign bus.start_address = start_addr_q;
    assign bus.busy          = busy_o;
    assign bus.done          = done_o;
    assign bus.timeout       = timeout_q;
    assign bus.prog_id       = prog_id_q;
    assign bus.cycle_count   = cycle_cnt_q;

endmodule
